// File: rtl/revaluate_controller.sv
// Sequencing FSM for the revaluate datapath: read -> load -> write for every line of every file.
// Optional pause input is enabled by defining REVAL_CTRL_PAUSE_EN.
module revaluate_controller #(
  parameter int FILE_W         = 10,
  parameter int LINE_W         = 6,
  parameter int NUM_FILES      = 1024,
  parameter int LINES_PER_FILE = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef REVAL_CTRL_PAUSE_EN
  input  logic              pause,
`endif
  output logic              busy,
  output logic              done,
  output logic              read_file,
  output logic              write_reg,
  output logic              write_file,
  output logic [FILE_W-1:0] file_index,
  output logic [LINE_W-1:0] line_index
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LOAD,
    S_WRITE,
    S_DONE
  } state_t;

  // Terminal values come from the parameters so non-power-of-two sizes stop correctly.
  localparam logic [FILE_W-1:0] LAST_FILE = FILE_W'(NUM_FILES - 1);
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES_PER_FILE - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [FILE_W-1:0] r_file;
  logic [FILE_W-1:0] w_file_nxt;
  logic [LINE_W-1:0] r_line;
  logic [LINE_W-1:0] w_line_nxt;
  logic              w_pause;
  logic              w_active;

`ifdef REVAL_CTRL_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_file  <= '0;
      r_line  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_file  <= w_file_nxt;
      r_line  <= w_line_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_file_nxt  = r_file;
    w_line_nxt  = r_line;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_READ;
          w_file_nxt  = '0;
          w_line_nxt  = '0;
        end
      end
      S_READ: begin
        if (!w_pause) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (!w_pause) w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (!w_pause) begin
          if (r_line != LAST_LINE) begin
            w_line_nxt  = r_line + LINE_W'(1);
            w_state_nxt = S_READ;
          end else if (r_file != LAST_FILE) begin
            w_line_nxt  = '0;
            w_file_nxt  = r_file + FILE_W'(1);
            w_state_nxt = S_READ;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_file_nxt  = '0;
        w_line_nxt  = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_file_nxt  = '0;
        w_line_nxt  = '0;
      end
    endcase
  end

  // Strobes are decoded from the registered state; pause masks them without leaving the state.
  assign w_active   = (r_state == S_READ) || (r_state == S_LOAD) || (r_state == S_WRITE);
  assign busy       = w_active;
  assign done       = (r_state == S_DONE);
  assign read_file  = (r_state == S_READ)  && !w_pause;
  assign write_reg  = (r_state == S_LOAD)  && !w_pause;
  assign write_file = (r_state == S_WRITE) && !w_pause;
  assign file_index = r_file;
  assign line_index = r_line;

endmodule

// File: tb/tb_revaluate_controller.sv
// Directed bench for revaluate_controller: 2x4 and 3x5 configurations, reset, start-while-busy,
// mid-pass reset and (when REVAL_CTRL_PAUSE_EN is defined) pause.
module tb_revaluate_controller;
  localparam int FW = 10;
  localparam int LW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, start_a;
  logic rst_b, start_b;
`ifdef REVAL_CTRL_PAUSE_EN
  logic pause_a;
`endif
  logic a_busy, a_done, a_rf, a_wr, a_wf;
  logic [FW-1:0] a_fi;
  logic [LW-1:0] a_li;
  logic b_busy, b_done, b_rf, b_wr, b_wf;
  logic [FW-1:0] b_fi;
  logic [LW-1:0] b_li;
  logic [20:0] obs_a, obs_b;

  assign obs_a = {a_rf, a_wr, a_wf, a_busy, a_done, a_fi, a_li};
  assign obs_b = {b_rf, b_wr, b_wf, b_busy, b_done, b_fi, b_li};

  int checks = 0;
  int failures = 0;

  revaluate_controller #(.FILE_W(FW), .LINE_W(LW), .NUM_FILES(2), .LINES_PER_FILE(4)) u_a (
    .clk(clk), .rst(rst_a), .start(start_a),
`ifdef REVAL_CTRL_PAUSE_EN
    .pause(pause_a),
`endif
    .busy(a_busy), .done(a_done), .read_file(a_rf), .write_reg(a_wr), .write_file(a_wf),
    .file_index(a_fi), .line_index(a_li)
  );

  revaluate_controller #(.FILE_W(FW), .LINE_W(LW), .NUM_FILES(3), .LINES_PER_FILE(5)) u_b (
    .clk(clk), .rst(rst_b), .start(start_b),
`ifdef REVAL_CTRL_PAUSE_EN
    .pause(1'b0),
`endif
    .busy(b_busy), .done(b_done), .read_file(b_rf), .write_reg(b_wr), .write_file(b_wf),
    .file_index(b_fi), .line_index(b_li)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected output vector {read_file, write_reg, write_file, busy, done, file, line}.
  function automatic logic [20:0] pack(input logic rf, input logic wr, input logic wf,
                                       input logic bz, input logic dn, input int f, input int l);
    logic [FW-1:0] fv;
    logic [LW-1:0] lv;
    fv = f[FW-1:0];
    lv = l[LW-1:0];
    return {rf, wr, wf, bz, dn, fv, lv};
  endfunction

  // Cycle c (1-based after start acceptance) of an unpaused pass: 3 cycles per line.
  function automatic logic [20:0] exp_pass(input int c, input int lines);
    int k, n, ph;
    k  = c - 1;
    n  = k / 3;
    ph = k % 3;
    return pack(ph == 0, ph == 1, ph == 2, 1'b1, 1'b0, n / lines, n % lines);
  endfunction

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b1; start_b = 1'b1;
    step();
    step();
    checks++;
    if (obs_a !== 21'd0) begin
      failures++;
      $display("FAIL reset_a: got %h expected %h", obs_a, 21'd0);
    end
    checks++;
    if (obs_b !== 21'd0) begin
      failures++;
      $display("FAIL reset_b: got %h expected %h", obs_b, 21'd0);
    end
    rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
    step();
    checks++;
    if (a_busy !== 1'b0 || obs_a !== 21'd0) begin
      failures++;
      $display("FAIL reset_idle_a: got %h expected %h", obs_a, 21'd0);
    end
  endtask

  task automatic test_full_pass();
    int wr;
    wr = 0;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      checks++;
      if (obs_a !== exp_pass(c, 4)) begin
        failures++;
        $display("FAIL full_pass cycle %0d: got %h expected %h", c, obs_a, exp_pass(c, 4));
      end
      if (a_wf) wr++;
      step();
    end
    checks++;
    if (obs_a !== pack(0, 0, 0, 0, 1, 1, 3)) begin
      failures++;
      $display("FAIL full_pass_done: got %h expected %h", obs_a, pack(0, 0, 0, 0, 1, 1, 3));
    end
    step();
    checks++;
    if (obs_a !== 21'd0) begin
      failures++;
      $display("FAIL full_pass_idle: got %h expected %h", obs_a, 21'd0);
    end
    checks++;
    if (wr != 8) begin
      failures++;
      $display("FAIL full_pass_writes: got %0d expected 8", wr);
    end
  endtask

  task automatic test_start_while_busy();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      start_a = (c == 5);
      #1;
      checks++;
      if (obs_a !== exp_pass(c, 4)) begin
        failures++;
        $display("FAIL busy_start cycle %0d: got %h expected %h", c, obs_a, exp_pass(c, 4));
      end
      step();
    end
    start_a = 1'b0;
    checks++;
    if (obs_a !== pack(0, 0, 0, 0, 1, 1, 3)) begin
      failures++;
      $display("FAIL busy_start_done: got %h expected %h", obs_a, pack(0, 0, 0, 0, 1, 1, 3));
    end
    step();
    checks++;
    if (obs_a !== 21'd0) begin
      failures++;
      $display("FAIL busy_start_idle: got %h expected %h", obs_a, 21'd0);
    end
  endtask

  task automatic test_mid_reset();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      checks++;
      if (obs_a !== exp_pass(c, 4)) begin
        failures++;
        $display("FAIL mid_reset_pre cycle %0d: got %h expected %h", c, obs_a, exp_pass(c, 4));
      end
      if (c != 20) step();
    end
    // Now in LOAD of (1,2).
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    checks++;
    if (obs_a !== 21'd0) begin
      failures++;
      $display("FAIL mid_reset_idle: got %h expected %h", obs_a, 21'd0);
    end
    step();
    checks++;
    if (obs_a !== 21'd0) begin
      failures++;
      $display("FAIL mid_reset_no_resume: got %h expected %h", obs_a, 21'd0);
    end
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      checks++;
      if (obs_a !== exp_pass(c, 4)) begin
        failures++;
        $display("FAIL mid_reset_rerun cycle %0d: got %h expected %h", c, obs_a, exp_pass(c, 4));
      end
      step();
    end
    checks++;
    if (obs_a !== pack(0, 0, 0, 0, 1, 1, 3)) begin
      failures++;
      $display("FAIL mid_reset_done: got %h expected %h", obs_a, pack(0, 0, 0, 0, 1, 1, 3));
    end
    step();
  endtask

  task automatic test_nonpow2();
    int wr, max_line, max_file;
    wr = 0; max_line = 0; max_file = 0;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      checks++;
      if (obs_b !== exp_pass(c, 5)) begin
        failures++;
        $display("FAIL nonpow2 cycle %0d: got %h expected %h", c, obs_b, exp_pass(c, 5));
      end
      if (b_wf) wr++;
      if (int'(b_li) > max_line) max_line = int'(b_li);
      if (int'(b_fi) > max_file) max_file = int'(b_fi);
      step();
    end
    checks++;
    if (obs_b !== pack(0, 0, 0, 0, 1, 2, 4)) begin
      failures++;
      $display("FAIL nonpow2_done: got %h expected %h", obs_b, pack(0, 0, 0, 0, 1, 2, 4));
    end
    checks++;
    if (max_line != 4) begin
      failures++;
      $display("FAIL nonpow2_max_line: got %0d expected 4", max_line);
    end
    checks++;
    if (max_file != 2) begin
      failures++;
      $display("FAIL nonpow2_max_file: got %0d expected 2", max_file);
    end
    checks++;
    if (wr != 15) begin
      failures++;
      $display("FAIL nonpow2_writes: got %0d expected 15", wr);
    end
    step();
    checks++;
    if (obs_b !== 21'd0) begin
      failures++;
      $display("FAIL nonpow2_idle: got %h expected %h", obs_b, 21'd0);
    end
  endtask

`ifdef REVAL_CTRL_PAUSE_EN
  task automatic test_pause();
    logic [20:0] e;
    int wr;
    wr = 0;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int c = 1; c <= 28; c++) begin
      pause_a = (c >= 6 && c <= 9);
      #1;
      if (c < 6) e = exp_pass(c, 4);
      else if (c <= 9) e = pack(0, 0, 0, 1, 0, 0, 1);
      else e = exp_pass(c - 4, 4);
      checks++;
      if (obs_a !== e) begin
        failures++;
        $display("FAIL pause cycle %0d: got %h expected %h", c, obs_a, e);
      end
      if (a_wf) wr++;
      step();
    end
    pause_a = 1'b0;
    #1;
    checks++;
    if (obs_a !== pack(0, 0, 0, 0, 1, 1, 3)) begin
      failures++;
      $display("FAIL pause_done: got %h expected %h", obs_a, pack(0, 0, 0, 0, 1, 1, 3));
    end
    checks++;
    if (wr != 8) begin
      failures++;
      $display("FAIL pause_writes: got %0d expected 8", wr);
    end
    step();
  endtask
`endif

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
`ifdef REVAL_CTRL_PAUSE_EN
    pause_a = 1'b0;
`endif
    test_reset();
    test_full_pass();
    test_start_while_busy();
    test_mid_reset();
    test_nonpow2();
`ifdef REVAL_CTRL_PAUSE_EN
    test_pause();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
